// File: rtl/mrv1_pkg.sv
// Shared types for the mrv1 multithreaded core thread-control slice.
package mrv1_pkg;

    typedef enum logic [1:0] {
        MRV_TH_IDLE  = 2'd0,
        MRV_TH_RUN   = 2'd1,
        MRV_TH_WAIT  = 2'd2,
        MRV_TH_DRAIN = 2'd3
    } mrv_th_state_e;

endpackage

// File: rtl/mrv1_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester after the last grant.
module mrv1_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt_oh,
    output logic [$clog2(N)-1:0] gnt_tid,
    output logic                 gnt_vld
);
    localparam int TW = $clog2(N);

    logic [TW-1:0] idx;

    // Walk from the lowest-priority slot (last itself) to the highest (last+1) so the
    // final overwrite leaves the nearest requester after the pointer. N is a power of 2,
    // so the wrap is plain truncation.
    always_comb begin
        gnt_tid = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = N; i >= 1; i--) begin
            idx = last + TW'(i);
            if (req[idx]) begin
                gnt_tid = idx;
                gnt_vld = 1'b1;
            end
        end
        gnt_oh          = '0;
        gnt_oh[gnt_tid] = gnt_vld;
    end

endmodule

// File: rtl/mrv1_thread_ctl.sv
// Per-thread run state and PC tracking, spawn/stop command handling and round-robin
// selection of the next thread offered to instruction fetch.
module mrv1_thread_ctl
    import mrv1_pkg::*;
#(
    parameter int                    NUM_THREADS_P = 4,
    parameter int                    PC_WIDTH_P    = 32,
    parameter logic [PC_WIDTH_P-1:0] RESET_PC_P    = '0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             th_ctl_vld_i,
    input  logic [$clog2(NUM_THREADS_P)-1:0] th_ctl_tid_i,
    input  logic                             th_ctl_tspawn_vld_i,
    input  logic [PC_WIDTH_P-1:0]            th_ctl_tspawn_pc_i,
    output logic                             fetch_vld_o,
    input  logic                             fetch_rdy_i,
    output logic [$clog2(NUM_THREADS_P)-1:0] fetch_tid_o,
    output logic [PC_WIDTH_P-1:0]            fetch_pc_o,
    input  logic                             pc_upd_vld_i,
    input  logic [$clog2(NUM_THREADS_P)-1:0] pc_upd_tid_i,
    input  logic [PC_WIDTH_P-1:0]            pc_upd_pc_i,
    output logic [NUM_THREADS_P-1:0]         active_mask_o,
    output logic                             all_idle_o,
    output logic                             th_ctl_err_o
);
    localparam int N            = NUM_THREADS_P;
    localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P);

    mrv_th_state_e           state_q    [N];
    mrv_th_state_e           state_d    [N];
    logic [PC_WIDTH_P-1:0]   pc_q       [N];
    logic [PC_WIDTH_P-1:0]   pc_d       [N];
    logic [PC_WIDTH_P-1:0]   spawn_pc_q [N];
    logic [PC_WIDTH_P-1:0]   spawn_pc_d [N];
    logic [N-1:0]            pend_q, pend_d;
    logic [TID_WIDTH_LP-1:0] ptr_q;
    logic                    hold_vld_q;
    logic [TID_WIDTH_LP-1:0] hold_tid_q;
    logic                    err_q, err_d;
    logic [N-1:0]            active_q, active_d;
    logic                    all_idle_q;

    logic [N-1:0]            run_vec;
    logic [N-1:0]            arb_oh, hold_oh, gnt_oh;
    logic [TID_WIDTH_LP-1:0] arb_tid, gnt_tid;
    logic                    arb_vld, hold_ok, gnt_vld, fire;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_decode
            assign run_vec[gi]  = (state_q[gi] == MRV_TH_RUN);
            assign active_d[gi] = (state_d[gi] != MRV_TH_IDLE);
        end
    endgenerate

    mrv1_rr_arb #(.N(N)) u_arb (
        .req     (run_vec),
        .last    (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_tid (arb_tid),
        .gnt_vld (arb_vld)
    );

    // An offer refused by fetch is pinned until accepted, unless that thread leaves RUN,
    // so newly runnable threads cannot steal a pending offer.
    assign hold_ok = hold_vld_q && (state_q[hold_tid_q] == MRV_TH_RUN);
    always_comb begin
        hold_oh             = '0;
        hold_oh[hold_tid_q] = 1'b1;
    end
    assign gnt_oh  = hold_ok ? hold_oh : arb_oh;
    assign gnt_tid = hold_ok ? hold_tid_q : arb_tid;
    assign gnt_vld = arb_vld;
    assign fire    = gnt_vld && fetch_rdy_i;

    assign fetch_vld_o = gnt_vld;
    assign fetch_tid_o = gnt_vld ? gnt_tid : '0;
    assign fetch_pc_o  = gnt_vld ? pc_q[gnt_tid] : '0;

    // Events on one thread compose in order: fetch grant, then pc_upd, then command.
    always_comb begin
        err_d  = 1'b0;
        pend_d = pend_q;
        for (int t = 0; t < N; t++) begin
            state_d[t]    = state_q[t];
            pc_d[t]       = pc_q[t];
            spawn_pc_d[t] = spawn_pc_q[t];

            if (fire && gnt_oh[t]) state_d[t] = MRV_TH_WAIT;

            if (pc_upd_vld_i && (pc_upd_tid_i == TID_WIDTH_LP'(t))) begin
                case (state_d[t])
                    MRV_TH_WAIT: begin
                        state_d[t] = MRV_TH_RUN;
                        pc_d[t]    = pc_upd_pc_i;
                    end
                    MRV_TH_DRAIN: begin
                        if (pend_d[t]) begin
                            state_d[t] = MRV_TH_RUN;
                            pc_d[t]    = spawn_pc_q[t];
                            pend_d[t]  = 1'b0;
                        end else begin
                            state_d[t] = MRV_TH_IDLE;
                        end
                    end
                    default: ;
                endcase
            end

            if (th_ctl_vld_i && (th_ctl_tid_i == TID_WIDTH_LP'(t))) begin
                if (th_ctl_tspawn_vld_i) begin
                    case (state_d[t])
                        MRV_TH_IDLE: begin
                            state_d[t] = MRV_TH_RUN;
                            pc_d[t]    = th_ctl_tspawn_pc_i;
                        end
                        MRV_TH_DRAIN: begin
                            if (pend_d[t]) begin
                                err_d = 1'b1;
                            end else begin
                                spawn_pc_d[t] = th_ctl_tspawn_pc_i;
                                pend_d[t]     = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end else begin
                    case (state_d[t])
                        MRV_TH_RUN:   state_d[t] = MRV_TH_IDLE;
                        MRV_TH_WAIT:  state_d[t] = MRV_TH_DRAIN;
                        MRV_TH_DRAIN: pend_d[t]  = 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < N; t++) begin
                state_q[t]    <= (t == 0) ? MRV_TH_RUN : MRV_TH_IDLE;
                pc_q[t]       <= (t == 0) ? RESET_PC_P : '0;
                spawn_pc_q[t] <= '0;
            end
            pend_q     <= '0;
            ptr_q      <= TID_WIDTH_LP'(N - 1);
            hold_vld_q <= 1'b0;
            hold_tid_q <= '0;
            err_q      <= 1'b0;
            active_q   <= N'(1);
            all_idle_q <= 1'b0;
        end else begin
            for (int t = 0; t < N; t++) begin
                state_q[t]    <= state_d[t];
                pc_q[t]       <= pc_d[t];
                spawn_pc_q[t] <= spawn_pc_d[t];
            end
            pend_q     <= pend_d;
            if (fire) ptr_q <= gnt_tid;
            hold_vld_q <= gnt_vld && !fetch_rdy_i;
            hold_tid_q <= gnt_tid;
            err_q      <= err_d;
            active_q   <= active_d;
            all_idle_q <= ~|active_d;
        end
    end

    assign active_mask_o = active_q;
    assign all_idle_o    = all_idle_q;
    assign th_ctl_err_o  = err_q;

endmodule

// File: tb/tb_mrv1_thread_ctl.sv
// Randomized bench for mrv1_thread_ctl against a rule-level thread model.
module tb_mrv1_thread_ctl;
    localparam int          N      = 4;
    localparam int          TW     = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0080;

    localparam int IDLE = 0, RUN = 1, WAIT = 2, DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          th_ctl_vld = 1'b0;
    logic [TW-1:0] th_ctl_tid = '0;
    logic          th_ctl_spawn = 1'b0;
    logic [31:0]   th_ctl_pc = '0;
    logic          fetch_vld;
    logic          fetch_rdy = 1'b0;
    logic [TW-1:0] fetch_tid;
    logic [31:0]   fetch_pc;
    logic          pc_upd_vld = 1'b0;
    logic [TW-1:0] pc_upd_tid = '0;
    logic [31:0]   pc_upd_pc = '0;
    logic [N-1:0]  active_mask;
    logic          all_idle;
    logic          th_ctl_err;

    mrv1_thread_ctl #(
        .NUM_THREADS_P (N),
        .PC_WIDTH_P    (32),
        .RESET_PC_P    (RST_PC)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .th_ctl_vld_i        (th_ctl_vld),
        .th_ctl_tid_i        (th_ctl_tid),
        .th_ctl_tspawn_vld_i (th_ctl_spawn),
        .th_ctl_tspawn_pc_i  (th_ctl_pc),
        .fetch_vld_o         (fetch_vld),
        .fetch_rdy_i         (fetch_rdy),
        .fetch_tid_o         (fetch_tid),
        .fetch_pc_o          (fetch_pc),
        .pc_upd_vld_i        (pc_upd_vld),
        .pc_upd_tid_i        (pc_upd_tid),
        .pc_upd_pc_i         (pc_upd_pc),
        .active_mask_o       (active_mask),
        .all_idle_o          (all_idle),
        .th_ctl_err_o        (th_ctl_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: thread states as plain integers, the last accepted thread,
    // and the offer pinned while fetch refuses it.
    int          m_st   [N];
    logic [31:0] m_pc   [N];
    logic [31:0] m_spc  [N];
    bit          m_pend [N];
    int          m_last;
    bit          m_hold;
    int          m_hold_tid;
    bit          m_err;

    task automatic model_reset();
        for (int t = 0; t < N; t++) begin
            m_st[t]   = (t == 0) ? RUN : IDLE;
            m_pc[t]   = (t == 0) ? RST_PC : 32'h0;
            m_spc[t]  = 32'h0;
            m_pend[t] = 1'b0;
        end
        m_last = N - 1;
        m_hold = 1'b0;
        m_hold_tid = 0;
        m_err = 1'b0;
    endtask

    function automatic void m_offer(output bit v, output int g);
        v = 1'b0;
        g = 0;
        if (m_hold && m_st[m_hold_tid] == RUN) begin
            v = 1'b1;
            g = m_hold_tid;
            return;
        end
        for (int k = 1; k <= N; k++) begin
            int t;
            t = (m_last + k) % N;
            if (m_st[t] == RUN) begin
                v = 1'b1;
                g = t;
                return;
            end
        end
    endfunction

    task automatic compare_all();
        bit v;
        int g;
        logic [N-1:0] mask;
        m_offer(v, g);
        mask = '0;
        for (int t = 0; t < N; t++) mask[t] = (m_st[t] != IDLE);
        chk("fetch_vld", 32'(fetch_vld), 32'(v));
        chk("fetch_tid", 32'(fetch_tid), v ? g : 0);
        chk("fetch_pc", fetch_pc, v ? m_pc[g] : 32'h0);
        chk("active_mask", 32'(active_mask), 32'(mask));
        chk("all_idle", 32'(all_idle), 32'(mask == '0));
        chk("th_ctl_err", 32'(th_ctl_err), 32'(m_err));
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit v;
        int g, t;
        bit e;
        m_offer(v, g);
        e = 1'b0;
        if (v && fetch_rdy) begin
            m_st[g] = WAIT;
            m_last = g;
        end
        m_hold = v && !fetch_rdy;
        m_hold_tid = g;
        if (pc_upd_vld) begin
            t = int'(pc_upd_tid);
            if (m_st[t] == WAIT) begin
                m_st[t] = RUN;
                m_pc[t] = pc_upd_pc;
            end else if (m_st[t] == DRAIN) begin
                if (m_pend[t]) begin
                    m_st[t] = RUN;
                    m_pc[t] = m_spc[t];
                    m_pend[t] = 1'b0;
                end else begin
                    m_st[t] = IDLE;
                end
            end
        end
        if (th_ctl_vld) begin
            t = int'(th_ctl_tid);
            if (th_ctl_spawn) begin
                if (m_st[t] == IDLE) begin
                    m_st[t] = RUN;
                    m_pc[t] = th_ctl_pc;
                end else if (m_st[t] == DRAIN && !m_pend[t]) begin
                    m_spc[t] = th_ctl_pc;
                    m_pend[t] = 1'b1;
                end else begin
                    e = 1'b1;
                end
            end else begin
                if (m_st[t] == RUN) m_st[t] = IDLE;
                else if (m_st[t] == WAIT) m_st[t] = DRAIN;
                else if (m_st[t] == DRAIN) m_pend[t] = 1'b0;
            end
        end
        m_err = e;
    endtask

    task automatic drive(input bit cv, input int ct, input bit csp, input logic [31:0] cpc,
                         input bit rdy, input bit uv, input int ut, input logic [31:0] upc);
        th_ctl_vld   = cv;
        th_ctl_tid   = TW'(ct);
        th_ctl_spawn = csp;
        th_ctl_pc    = cpc;
        fetch_rdy    = rdy;
        pc_upd_vld   = uv;
        pc_upd_tid   = TW'(ut);
        pc_upd_pc    = upc;
        model_step();
    endtask

    task automatic random_cycle(input int cyc);
        bit cv, csp, rdy, uv;
        int ct, ut;
        logic [31:0] cpc, upc;
        int outs[$];
        cv  = ($urandom % 100) < 30;
        ct  = $urandom % N;
        csp = ($urandom % 2) == 1;
        cpc = $urandom & 32'hFFFF_FFFC;
        rdy = ($urandom % 100) < 70;
        uv  = ($urandom % 100) < 60;
        upc = $urandom & 32'hFFFF_FFFC;
        for (int t = 0; t < N; t++) if (m_st[t] == WAIT || m_st[t] == DRAIN) outs.push_back(t);
        if (outs.size() > 0 && ($urandom % 4) != 0) ut = outs[$urandom % outs.size()];
        else ut = $urandom % N;
        drive(cv, ct, csp, cpc, rdy, uv, ut, upc);
        $display("cyc %0d cmd v%0d t%0d spawn%0d pc %h | rdy %0d | upd v%0d t%0d pc %h | fetch v%0d t%0d pc %h mask %b err %0d",
                 cyc, cv, ct, csp, cpc, rdy, uv, ut, upc, fetch_vld, fetch_tid, fetch_pc,
                 active_mask, th_ctl_err);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            compare_all();
            random_cycle(cyc);

            if (cyc == 700) begin
                // Asynchronous reset mid-run: outputs must return to reset values at once.
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                th_ctl_vld = 1'b0;
                pc_upd_vld = 1'b0;
                fetch_rdy  = 1'b0;
                #1;
                chk("rst_fetch_vld", 32'(fetch_vld), 32'd1);
                chk("rst_fetch_tid", 32'(fetch_tid), 32'd0);
                chk("rst_fetch_pc", fetch_pc, RST_PC);
                chk("rst_mask", 32'(active_mask), 32'd1);
                chk("rst_all_idle", 32'(all_idle), 32'd0);
                chk("rst_err", 32'(th_ctl_err), 32'd0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                compare_all();
                model_step();
            end
        end

        // Stop everything, then return the outstanding fetches: all threads end IDLE.
        for (int t = 0; t < N; t++) begin
            @(negedge clk);
            compare_all();
            drive(1'b1, t, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0);
        end
        for (int t = 0; t < N; t++) begin
            @(negedge clk);
            compare_all();
            drive(1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b1, t, 32'h0000_0444);
        end
        @(negedge clk);
        compare_all();
        drive(1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0);
        @(negedge clk);
        compare_all();
        chk("all_idle_end", 32'(all_idle), 32'd1);
        chk("fetch_vld_end", 32'(fetch_vld), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
